cache_ctrl: RTL

Cache controller FSM that initiates every access to the 2-way, 64-line, 4-word-line `cache` array. It accepts CPU load/store requests, drives the array's `load`/`edit`/`store` strobes, and on a miss writes back a dirty victim line and refills the line from main memory word by word. The block sits between the CPU pipeline's memory stage, the `cache` instance and the memory port.

---
 rtl/cache_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// Cache controller for the 2-way, 64-line, 4-word-line cache array: serves CPU
// loads/stores, writes back dirty victims and refills missing lines word by word.
module cache_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 23,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [2:0]           cpu_u_b_h_w,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [31:0]          cache_dout,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [31:0]          mem_dout,
    input  logic [31:0]          mem_din,
    input  logic                 mem_ack
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int LINE_BITS = ADDR_BITS - WORD_BITS - 2;
    localparam int INDEX_HI  = ADDR_BITS - TAG_BITS - 1;
    localparam int INDEX_LEN = INDEX_HI - WORD_BITS - 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TAG_CHECK = 3'd1;
    localparam logic [2:0] BACK_RD   = 3'd2;
    localparam logic [2:0] BACK_WR   = 3'd3;
    localparam logic [2:0] FILL      = 3'd4;

    localparam logic [2:0]           FULL_WORD = 3'b010;
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    logic [2:0]           state, state_nxt;
    logic [WORD_BITS-1:0] k, k_nxt;
    logic [TAG_BITS-1:0]  victim_tag, victim_tag_nxt;
    logic [LINE_BITS-1:0] req_line, req_line_nxt;

    logic                 cpu_req;
    logic [ADDR_BITS-1:0] line_word_addr;
    logic [ADDR_BITS-1:0] victim_word_addr;

    assign cpu_req          = cpu_rd | cpu_wr;
    assign line_word_addr   = {req_line, k, 2'b00};
    assign victim_word_addr = {victim_tag, req_line[INDEX_LEN-1:0], k, 2'b00};

    assign cpu_dout      = cache_dout;
    assign cache_invalid = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            victim_tag <= '0;
            req_line   <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            victim_tag <= victim_tag_nxt;
            req_line   <= req_line_nxt;
        end
    end

    // Strobes in IDLE are masked while reset is held, since state is already IDLE then.
    always_comb begin
        state_nxt      = state;
        k_nxt          = k;
        victim_tag_nxt = victim_tag;
        req_line_nxt   = req_line;
        cache_addr     = cpu_addr;
        cache_u_b_h_w  = cpu_u_b_h_w;
        cache_din      = cpu_din;
        cache_load     = 1'b0;
        cache_store    = 1'b0;
        cache_edit     = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = line_word_addr;
        mem_dout       = cache_dout;
        cpu_stall      = 1'b1;

        case (state)
            IDLE: begin
                cpu_stall = cpu_req;
                if (rst) begin
                    cache_edit = cpu_wr;
                    cache_load = cpu_rd & ~cpu_wr;
                end
                if (cpu_req) begin
                    state_nxt    = TAG_CHECK;
                    req_line_nxt = cpu_addr[ADDR_BITS-1:WORD_BITS+2];
                end
            end

            TAG_CHECK: begin
                if (cache_hit) begin
                    cpu_stall = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    victim_tag_nxt = cache_tag;
                    k_nxt          = '0;
                    state_nxt      = (cache_valid && cache_dirty) ? BACK_RD : FILL;
                end
            end

            // Address with no strobe makes the array present the victim word next cycle.
            BACK_RD: begin
                cache_addr    = line_word_addr;
                cache_u_b_h_w = FULL_WORD;
                state_nxt     = BACK_WR;
            end

            BACK_WR: begin
                cache_addr    = line_word_addr;
                cache_u_b_h_w = FULL_WORD;
                mem_wr        = 1'b1;
                mem_addr      = victim_word_addr;
                if (mem_ack) begin
                    if (k == LAST_WORD) begin
                        k_nxt     = '0;
                        state_nxt = FILL;
                    end else begin
                        k_nxt     = k + 1'b1;
                        state_nxt = BACK_RD;
                    end
                end
            end

            FILL: begin
                mem_rd        = 1'b1;
                cache_addr    = line_word_addr;
                cache_u_b_h_w = FULL_WORD;
                cache_din     = mem_din;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    k_nxt       = k + 1'b1;
                    if (k == LAST_WORD) begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Protocol properties that must hold in every state.
    assert property (@(posedge clk) disable iff (!rst) !(mem_rd && mem_wr));
    assert property (@(posedge clk) disable iff (!rst) $onehot0({cache_load, cache_edit, cache_store}));

endmodule
